// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: access-size encoding,
// FSM states, size decoding and load-data extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_W = 2'b00,
        SZ_H = 2'b01,
        SZ_B = 2'b10,
        SZ_D = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [3:0] size_bytes(input mem_size_t size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            SZ_D:    n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Bits above the access size become the size MSB (signed) or zero.
    function automatic logic [63:0] sext_load(input logic [63:0] data,
                                              input mem_size_t size,
                                              input logic      sgn);
        logic [63:0] r;
        case (size)
            SZ_B:    r = {{56{sgn & data[7]}},  data[7:0]};
            SZ_H:    r = {{48{sgn & data[15]}}, data[15:0]};
            SZ_W:    r = {{32{sgn & data[31]}}, data[31:0]};
            SZ_D:    r = data;
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester above ptr_i
// (modulo NUM_REQ) that has its request bit set.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic          found_s;
    logic [PW-1:0] idx_s;

    // Walk the ring once, starting just after the pointer; first hit wins.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s          = PW'((int'(ptr_i) + k) % NUM_REQ);
            grant_o[idx_s] = req_i[idx_s] & ~found_s;
            found_s        = found_s | req_i[idx_s];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates NUM_REQ requesters onto one byte-addressed data memory using a
// fixed IDLE -> ACCESS -> RESP transaction with alignment and range checking.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MEM_BYTES = 88
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [2*NUM_REQ-1:0]  req_size,
    input  logic [NUM_REQ-1:0]    req_signed,
    input  logic [64*NUM_REQ-1:0] req_addr,
    input  logic [64*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [63:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [1:0]            mem_size,
    output logic [63:0]           mem_addr,
    output logic [63:0]           mem_wdata,
    input  logic [63:0]           mem_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic               write_q, write_d;
    logic               signed_q, signed_d;
    logic               err_q, err_d;
    mem_size_t          mem_size_q, mem_size_d;
    logic [63:0]        mem_addr_q, mem_addr_d;
    logic [63:0]        mem_wdata_q, mem_wdata_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_read_q, mem_read_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [63:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] grant_s;
    logic [PW-1:0]      sel_idx_s;
    logic [1:0]         sel_size_s;
    logic [63:0]        sel_addr_s;
    logic [63:0]        sel_wdata_s;
    logic               sel_write_s;
    logic               sel_signed_s;
    logic [3:0]         sel_bytes_s;
    logic [64:0]        sel_end_s;
    logic               sel_err_s;
    logic               xfer_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s)
    );

    // Encode the one-hot grant and pick out the winning request's fields.
    always_comb begin
        sel_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_idx_s = sel_idx_s | (grant_s[i] ? PW'(i) : '0);
        end
        sel_size_s   = req_size[2*int'(sel_idx_s) +: 2];
        sel_addr_s   = req_addr[64*int'(sel_idx_s) +: 64];
        sel_wdata_s  = req_wdata[64*int'(sel_idx_s) +: 64];
        sel_write_s  = req_write[sel_idx_s];
        sel_signed_s = req_signed[sel_idx_s];
        sel_bytes_s  = size_bytes(mem_size_t'(sel_size_s));
        // 65-bit end address so a request near 2^64 cannot wrap into range.
        sel_end_s    = {1'b0, sel_addr_s} + {61'd0, sel_bytes_s};
        sel_err_s    = (|(sel_addr_s[3:0] & (sel_bytes_s - 4'd1)))
                     | (sel_end_s > 65'(MEM_BYTES));
    end

    assign xfer_s    = (state_q == ST_IDLE) & (|grant_s);
    assign req_ready = grant_s & {NUM_REQ{(state_q == ST_IDLE) & rst_n}};

    // Next-state and registered-output logic for the three-state transaction.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        write_d     = write_q;
        signed_d    = signed_q;
        err_d       = err_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = 64'd0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    owner_d     = sel_idx_s;
                    ptr_d       = sel_idx_s;
                    write_d     = sel_write_s;
                    signed_d    = sel_signed_s;
                    err_d       = sel_err_s;
                    mem_size_d  = mem_size_t'(sel_size_s);
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    mem_write_d = sel_write_s & ~sel_err_s;
                    mem_read_d  = ~sel_write_s & ~sel_err_s;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
                rsp_err_d   = err_q;
                if (write_q | err_q) begin
                    rsp_rdata_d = 64'd0;
                end else begin
                    rsp_rdata_d = sext_load(mem_rdata, mem_size_q, signed_q);
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PW'(NUM_REQ - 1);
            owner_q     <= '0;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            mem_size_q  <= SZ_W;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            err_q       <= err_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates NUM_REQ requesters (e.g. the load/store stage and a debug/DMA loader) onto the single byte-addressed dataMemory port.
- Sequences each access as a fixed three-state transaction.
- Checks alignment and range, then returns size-correct, optionally sign-extended read data to the owning requester.
- Sits between the pipeline MEM stage and dataMemory; it drives dataMemory's memWrite, memRead, sizeSelect, address and writeData, and consumes readData.

Parameters:
- NUM_REQ, 2, number of requesters; round-robin fairness.
- MEM_BYTES, 88, size of the data memory in bytes (11 doublewords); used for the range check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are high at a rising edge.
- req_write  in  NUM_REQ  1 = store, 0 = load.
- req_size  in  2*NUM_REQ  access size; 00 = W, 01 = H, 10 = B, 11 = D.
- req_signed  in  NUM_REQ  sign-extend load data.
- req_addr  in  64*NUM_REQ  byte address.
- req_wdata  in  64*NUM_REQ  store data, right-aligned.
- rsp_valid  out  NUM_REQ  one-hot; one-cycle response pulse to the owner.
- rsp_rdata  out  64  load data, shared across requesters; valid only with rsp_valid.
- rsp_err  out  1  access rejected; valid only with rsp_valid.
- mem_write  out  1  to dataMemory memWrite.
- mem_read  out  1  to dataMemory memRead.
- mem_size  out  2  to dataMemory sizeSelect.
- mem_addr  out  64  to dataMemory address.
- mem_wdata  out  64  to dataMemory writeData.
- mem_rdata  in  64  from dataMemory readData.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - req_ready, rsp_valid, mem_write, mem_read all 0.
  - mem_size, mem_addr, mem_wdata, rsp_rdata = 0; rsp_err = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins the first tie.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. One transaction in flight; throughput is one access per 3 cycles.
- IDLE:
  - req_ready is combinational: one-hot to the first requester with req_valid high, searching upward from pointer+1 modulo NUM_REQ.
  - On a transfer: latch owner, write, size, signed, addr, wdata; compute err; set pointer = owner; go to ACCESS.
  - If no req_valid is high, stay in IDLE.
- req_ready is 0 in ACCESS and RESP.
- err is 1 if either condition holds:
  - addr is not a multiple of the size in bytes (B=1, H=2, W=4, D=8);
  - addr + size bytes > MEM_BYTES. Evaluate in 65 bits, so there is no wrap at 2^64.
- ACCESS:
  - mem_addr, mem_size, mem_wdata are driven from the latched request.
  - mem_write = write & !err; mem_read = !write & !err.
  - dataMemory acts at the rising edge ending ACCESS. Go to RESP.
- RESP:
  - rsp_valid[owner] = 1; rsp_err = err.
  - rsp_rdata:
    - 0 for stores and for errors;
    - otherwise mem_rdata with bits above the access size replaced by the size MSB (bit 7, 15 or 31) when signed = 1, or zero when signed = 0;
    - D loads pass through unchanged.
  - mem_write and mem_read are 0. Go to IDLE.
- Latency from the transfer edge: rsp_valid is high in the second cycle after it (IDLE -> ACCESS -> RESP). Errors use the same latency.
- Mem strobes are high for exactly one cycle per access and never during an error.
- A requester may drop req_valid before it is granted; no state changes.
- A requester may hold req_valid through RESP; it is eligible again in the next IDLE.
- Reset mid-ACCESS or mid-RESP aborts the transaction: no rsp_valid is issued, and strobes drop asynchronously.
- Bits of mem_addr above the range check are passed through unmodified.

Decomposition:
- Package dmem_pkg:
  - mem_size_t enum (W=2'b00, H=2'b01, B=2'b10, D=2'b11), matching memory_opcode.svh.
  - state enum {IDLE, ACCESS, RESP}.
  - Function size_bytes(mem_size_t).
  - Function sext_load(data, size, signed).
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: req vector, pointer.
  - Output: one-hot grant (combinational).

Test Plan:
- After reset, req0 stores D 0x1122334455667788 at addr 8 -> mem_write high only in the cycle after the transfer; rsp_valid[0] two cycles after the transfer; rsp_err = 0.
- req0 loads B at 8 with signed = 1 -> rsp_rdata 0xFFFFFFFFFFFFFF88. Same with signed = 0 -> 0x0000000000000088. Load H at 14 with signed = 1 -> 0x0000000000001122.
- Load W at addr 2 -> rsp_err = 1, rsp_rdata = 0, mem_read never high. Load D at addr 80 -> ok. Store D at 88 -> rsp_err = 1, mem_write never high. Addr 0xFFFFFFFFFFFFFFF8 D -> rsp_err = 1.
- req0 and req1 both valid continuously from reset -> grants 0,1,0,1 on successive IDLE cycles; each rsp_valid goes only to its own index.
- rst_n pulsed low during ACCESS of a store -> mem_write drops immediately, no rsp_valid, FSM in IDLE, first grant after release goes to req0.
- req1 asserts req_valid for one cycle while the FSM is in ACCESS, then drops it -> no grant, no state change.
